// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Default geometry plus the one-hot address decoder.
package register_file_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  function automatic logic [DEPTH-1:0] onehot_decode(
    input reg_addr_t a
  );
    logic [DEPTH-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Bus bundle between issue/write-back logic and the register file.
// master drives addresses and writes, slave returns read data and busy.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = AW,
  parameter int DATA_WIDTH    = DW,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 1
);

  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr_i;
  logic [NUM_READ*DATA_WIDTH-1:0]     rd_data_o;
  logic [NUM_READ-1:0]                rd_busy_o;
  logic [NUM_WRITE-1:0]               wr_en_i;
  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr_i;
  logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data_i;
  logic                               busy_set_i;
  logic [ADDRESS_WIDTH-1:0]           busy_set_addr_i;
  logic                               flush_i;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    output busy_set_i, busy_set_addr_i, flush_i,
    input  rd_data_o, rd_busy_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    input  busy_set_i, busy_set_addr_i, flush_i,
    output rd_data_o, rd_busy_o
  );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Busy bit per register with set/clear/flush priority.
// A new producer (set) always beats a retiring one (clear/flush).
module rf_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = AW,
  parameter int NUM_READ      = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [(1<<ADDRESS_WIDTH)-1:0]       i_clr,
  input  logic                                i_set,
  input  logic [ADDRESS_WIDTH-1:0]            i_set_addr,
  input  logic                                i_flush,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]   i_rd_addr,
  output logic [NUM_READ-1:0]                 o_busy
);

  localparam int RDEPTH = 1 << ADDRESS_WIDTH;

  logic [RDEPTH-1:0] r_busy;
  logic [RDEPTH-1:0] w_set;
  logic [RDEPTH-1:0] w_next;

  // next busy vector: flush or clear drop bits, set re-arms
  always_comb begin
    w_set = '0;
    if (i_set)
      w_set = onehot_decode(reg_addr_t'(i_set_addr));
    if (ZERO_REG != 0)
      w_set[0] = 1'b0;
    if (i_flush)
      w_next = w_set;
    else
      w_next = (r_busy & ~i_clr) | w_set;
  end

  // busy state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_busy <= '0;
    else
      r_busy <= w_next;
  end

  // per-port lookup
  always_comb begin
    o_busy = '0;
    for (int p = 0; p < NUM_READ; p++)
      o_busy[p] = r_busy[i_rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass.
// Storage and bypass muxes live here; busy tracking is in rf_scoreboard.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = AW,
  parameter int DATA_WIDTH    = DW,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 1,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  register_file_if.slave  bus
);

  localparam int RDEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    r_rf [RDEPTH];
  logic [RDEPTH-1:0]        w_wr_oh [NUM_WRITE];
  logic [RDEPTH-1:0]        w_wr_any;
  logic [NUM_READ-1:0]      w_sb_busy;
  logic [ADDRESS_WIDTH-1:0] w_ra [NUM_READ];
  logic [DATA_WIDTH-1:0]    w_rd [NUM_READ];
  logic [NUM_READ-1:0]      w_hit;

  // decode each write port; register 0 is masked when hardwired
  always_comb begin
    w_wr_any = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      w_wr_oh[w] = '0;
      if (bus.wr_en_i[w])
        w_wr_oh[w] = onehot_decode(reg_addr_t'(
          bus.wr_addr_i[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]));
      if (ZERO_REG != 0)
        w_wr_oh[w][0] = 1'b0;
      w_wr_any = w_wr_any | w_wr_oh[w];
    end
  end

  // storage; later ports are applied last so the highest index wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < RDEPTH; r++)
        r_rf[r] <= '0;
    end else begin
      for (int r = 0; r < RDEPTH; r++)
        for (int w = 0; w < NUM_WRITE; w++)
          if (w_wr_oh[w][r])
            r_rf[r] <= bus.wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // read muxes with bypass, zero register and reset gating
  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      w_ra[p]  = bus.rd_addr_i[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      w_rd[p]  = r_rf[w_ra[p]];
      w_hit[p] = 1'b0;
      if (BYPASS != 0)
        for (int w = 0; w < NUM_WRITE; w++)
          if (bus.wr_en_i[w] &&
              bus.wr_addr_i[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == w_ra[p]) begin
            w_rd[p]  = bus.wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
            w_hit[p] = 1'b1;
          end
      if (ZERO_REG != 0 && w_ra[p] == '0)
        w_rd[p] = '0;
      if (!rst_ni)
        w_rd[p] = '0;
      bus.rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = w_rd[p];
      bus.rd_busy_o[p] = w_sb_busy[p] & ~w_hit[p] & rst_ni;
    end
  end

  rf_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .ZERO_REG      (ZERO_REG)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_clr      (w_wr_any),
    .i_set      (bus.busy_set_i),
    .i_set_addr (bus.busy_set_addr_i),
    .i_flush    (bus.flush_i),
    .i_rd_addr  (bus.rd_addr_i),
    .o_busy     (w_sb_busy)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed table-driven bench for register_file_mp.
// Runs a bypassing and a non-bypassing instance on the same stimulus.
module tb_register_file_mp;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  register_file_if #(
    .ADDRESS_WIDTH(5), .DATA_WIDTH(32),
    .NUM_READ(2), .NUM_WRITE(2)
  ) bb ();
  register_file_if #(
    .ADDRESS_WIDTH(5), .DATA_WIDTH(32),
    .NUM_READ(2), .NUM_WRITE(2)
  ) bn ();

  assign bn.rd_addr_i       = bb.rd_addr_i;
  assign bn.wr_en_i         = bb.wr_en_i;
  assign bn.wr_addr_i       = bb.wr_addr_i;
  assign bn.wr_data_i       = bb.wr_data_i;
  assign bn.busy_set_i      = bb.busy_set_i;
  assign bn.busy_set_addr_i = bb.busy_set_addr_i;
  assign bn.flush_i         = bb.flush_i;

  register_file_mp #(
    .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2),
    .NUM_WRITE(2), .BYPASS(1), .ZERO_REG(1)
  ) u_byp (
    .clk_i(clk), .rst_ni(rst_n), .bus(bb.slave)
  );

  register_file_mp #(
    .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2),
    .NUM_WRITE(2), .BYPASS(0), .ZERO_REG(1)
  ) u_nob (
    .clk_i(clk), .rst_ni(rst_n), .bus(bn.slave)
  );

  typedef struct {
    string       nm;
    logic        we0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        set;
    logic [4:0]  sa;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        eb0;
    logic        eb1;
    logic [31:0] n0;
    logic        nb0;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bb.wr_en_i         = '0;
    bb.wr_addr_i       = '0;
    bb.wr_data_i       = '0;
    bb.busy_set_i      = 1'b0;
    bb.busy_set_addr_i = '0;
    bb.flush_i         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //     nm  we0 a0 d0  we1 a1 d1  set sa fl  r0 r1  e0 e1  eb0 eb1  n0 nb0
    vt[0]  = '{"w5_byp",     1,5,32'hDEADBEEF, 0,0,0,  0,0,0, 5,0,
               32'hDEADBEEF,0, 0,0, 0,0};
    vt[1]  = '{"r5_next",    0,0,0, 0,0,0,  0,0,0, 5,5,
               32'hDEADBEEF,32'hDEADBEEF, 0,0, 32'hDEADBEEF,0};
    vt[2]  = '{"w0_drop",    1,0,32'h1234, 0,0,0,  0,0,0, 0,0,
               0,0, 0,0, 0,0};
    vt[3]  = '{"set_r0",     0,0,0, 0,0,0,  1,0,0, 0,5,
               0,32'hDEADBEEF, 0,0, 0,0};
    vt[4]  = '{"r0_nobusy",  0,0,0, 0,0,0,  0,0,0, 0,0,
               0,0, 0,0, 0,0};
    vt[5]  = '{"collide",    1,7,32'h11, 1,7,32'h22,  0,0,0, 7,7,
               32'h22,32'h22, 0,0, 0,0};
    vt[6]  = '{"r7_stored",  0,0,0, 0,0,0,  0,0,0, 7,5,
               32'h22,32'hDEADBEEF, 0,0, 32'h22,0};
    vt[7]  = '{"set9",       0,0,0, 0,0,0,  1,9,0, 9,9,
               0,0, 0,0, 0,0};
    vt[8]  = '{"w9_set9",    1,9,32'h99, 0,0,0,  1,9,0, 9,9,
               32'h99,32'h99, 0,0, 0,1};
    vt[9]  = '{"r9_busy",    0,0,0, 0,0,0,  0,0,0, 9,9,
               32'h99,32'h99, 1,1, 32'h99,1};
    vt[10] = '{"w9_clr",     1,9,32'h9A, 0,0,0,  0,0,0, 9,9,
               32'h9A,32'h9A, 0,0, 32'h99,1};
    vt[11] = '{"r9_clr",     0,0,0, 0,0,0,  0,0,0, 9,9,
               32'h9A,32'h9A, 0,0, 32'h9A,0};
    vt[12] = '{"set3",       0,0,0, 0,0,0,  1,3,0, 3,4,
               0,0, 0,0, 0,0};
    vt[13] = '{"set4",       0,0,0, 0,0,0,  1,4,0, 3,4,
               0,0, 1,0, 0,1};
    vt[14] = '{"flush",      0,0,0, 0,0,0,  0,0,1, 3,4,
               0,0, 1,1, 0,1};
    vt[15] = '{"post_flush", 0,0,0, 0,0,0,  0,0,0, 3,4,
               0,0, 0,0, 0,0};
    vt[16] = '{"flush_set3", 0,0,0, 0,0,0,  1,3,1, 3,4,
               0,0, 0,0, 0,0};
    vt[17] = '{"post_fs",    0,0,0, 0,0,0,  0,0,0, 3,4,
               0,0, 1,0, 0,1};
    vt[18] = '{"w2_set2",    1,2,32'hA5, 0,0,0,  1,2,0, 2,3,
               32'hA5,0, 0,1, 0,0};
    vt[19] = '{"r2_busy",    0,0,0, 0,0,0,  0,0,0, 2,2,
               32'hA5,32'hA5, 1,1, 32'hA5,1};

    idle();
    bb.rd_addr_i = {5'd5, 5'd5};
    #1;
    chk("in_reset_data", bb.rd_data_o[31:0], 32'h0);
    chk("in_reset_busy", {30'b0, bb.rd_busy_o}, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    for (int r = 0; r < 32; r++) begin
      bb.rd_addr_i = {5'(31 - r), 5'(r)};
      #1;
      chk($sformatf("rst_d0_r%0d", r), bb.rd_data_o[31:0], 32'h0);
      chk($sformatf("rst_d1_r%0d", r), bb.rd_data_o[63:32], 32'h0);
      chk($sformatf("rst_b_r%0d", r), {30'b0, bb.rd_busy_o}, 32'h0);
      chk($sformatf("rst_nd_r%0d", r), bn.rd_data_o[31:0], 32'h0);
    end
    step();

    for (int i = 0; i < 20; i++) begin
      bb.wr_en_i         = {vt[i].we1, vt[i].we0};
      bb.wr_addr_i       = {vt[i].a1, vt[i].a0};
      bb.wr_data_i       = {vt[i].d1, vt[i].d0};
      bb.busy_set_i      = vt[i].set;
      bb.busy_set_addr_i = vt[i].sa;
      bb.flush_i         = vt[i].fl;
      bb.rd_addr_i       = {vt[i].r1, vt[i].r0};
      #1;
      chk({vt[i].nm, "/d0"}, bb.rd_data_o[31:0], vt[i].e0);
      chk({vt[i].nm, "/d1"}, bb.rd_data_o[63:32], vt[i].e1);
      chk({vt[i].nm, "/b0"}, {31'b0, bb.rd_busy_o[0]}, {31'b0, vt[i].eb0});
      chk({vt[i].nm, "/b1"}, {31'b0, bb.rd_busy_o[1]}, {31'b0, vt[i].eb1});
      chk({vt[i].nm, "/nd0"}, bn.rd_data_o[31:0], vt[i].n0);
      chk({vt[i].nm, "/nb0"}, {31'b0, bn.rd_busy_o[0]}, {31'b0, vt[i].nb0});
      step();
    end

    // reset mid-cycle with a write to r2 and a set of r6 in flight
    idle();
    bb.wr_en_i         = 2'b10;
    bb.wr_addr_i       = {5'd2, 5'd0};
    bb.wr_data_i       = {32'h55, 32'h0};
    bb.busy_set_i      = 1'b1;
    bb.busy_set_addr_i = 5'd6;
    bb.rd_addr_i       = {5'd2, 5'd2};
    #1;
    chk("pre_rst_byp", bb.rd_data_o[31:0], 32'h55);
    chk("pre_rst_nob", bn.rd_data_o[31:0], 32'hA5);
    rst_n = 1'b0;
    #1;
    chk("arst_d0", bb.rd_data_o[31:0], 32'h0);
    chk("arst_d1", bb.rd_data_o[63:32], 32'h0);
    chk("arst_b", {30'b0, bb.rd_busy_o}, 32'h0);
    chk("arst_nd", bn.rd_data_o[31:0], 32'h0);
    chk("arst_nb", {30'b0, bn.rd_busy_o}, 32'h0);
    step();
    idle();
    rst_n = 1'b1;
    bb.rd_addr_i = {5'd6, 5'd2};
    #1;
    chk("post_rst_r2", bb.rd_data_o[31:0], 32'h0);
    chk("post_rst_b", {30'b0, bb.rd_busy_o}, 32'h0);
    step();
    chk("post_rst_r2b", bn.rd_data_o[31:0], 32'h0);
    chk("post_rst_b6", {30'b0, bn.rd_busy_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
